// File: rtl/sys_array_row.sv
// One weight-stationary systolic row: COLS signed MAC cells sharing a left->right activation stream.
// Latency: psum_out[j] 1+j cycles after activation accept, data_out COLS cycles; 1 activation/clk.
// Backpressure: in_ready drops only while draining for a weight swap; SYS_ROW_SAT_EN enables saturating adds.
module sys_array_row #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int COLS       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wt_valid,
  input  logic [DATA_WIDTH-1:0]     wt_data,
  output logic                      wt_ready,
  input  logic                      wt_swap,
  output logic                      swap_done,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  input  logic [COLS*ACC_WIDTH-1:0] psum_in,
  output logic [COLS*ACC_WIDTH-1:0] psum_out,
  output logic [COLS-1:0]           psum_valid,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic [COLS-1:0]           ovf
);

  localparam int CNT_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PROD_W = 2*DATA_WIDTH;

  typedef enum logic [1:0] {ST_LOAD, ST_FULL, ST_DRAIN} state_t;

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 cnt;
  logic [COLS-1:0][DATA_WIDTH-1:0]  shadow_w;
  logic [COLS-1:0][DATA_WIDTH-1:0]  active_w;
  logic [COLS-1:0][DATA_WIDTH-1:0]  act_q;
  logic [COLS-1:0]                  act_vld;
  logic                             wt_fire;
  logic                             in_fire;
  logic                             drained;
  logic                             do_swap;
  logic                             last_beat;

  assign wt_fire   = wt_valid & wt_ready;
  assign in_fire   = in_valid & in_ready;
  assign last_beat = (cnt == CNT_W'(COLS-1));
  // act_vld covers every in-flight activation, including the one that becomes data_valid
  assign drained   = ~(|act_vld) & ~(|psum_valid);

  always_comb begin
    state_nxt = state;
    wt_ready  = 1'b0;
    in_ready  = 1'b1;
    do_swap   = 1'b0;
    case (state)
      ST_LOAD: begin
        wt_ready = 1'b1;
        if (wt_valid && last_beat) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (wt_swap) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        in_ready = 1'b0;
        if (drained) begin
          do_swap   = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      shadow_w  <= '0;
      active_w  <= '0;
      swap_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      swap_done <= do_swap;
      if (wt_fire) begin
        shadow_w[cnt] <= wt_data;
        cnt           <= last_beat ? '0 : cnt + 1'b1;
      end
      if (do_swap) active_w <= shadow_w;
    end
  end

  // Activation shift chain; stages hold their data when no valid passes through
  always_ff @(posedge clk) begin
    if (reset) begin
      act_vld <= '0;
      act_q   <= '0;
    end else begin
      act_vld <= {act_vld[COLS-2:0], in_fire};
      if (in_fire) act_q[0] <= in_data;
      for (int k = 1; k < COLS; k++) begin
        if (act_vld[k-1]) act_q[k] <= act_q[k-1];
      end
    end
  end

  assign data_out   = act_q[COLS-1];
  assign data_valid = act_vld[COLS-1];

  for (genvar j = 0; j < COLS; j++) begin : g_cell
    logic [DATA_WIDTH-1:0] x;
    logic                  v;
    logic [PROD_W-1:0]     x_ext;
    logic [PROD_W-1:0]     w_ext;
    logic [PROD_W-1:0]     prod;
    logic [ACC_WIDTH-1:0]  pin;
    logic [ACC_WIDTH-1:0]  res;
    logic [ACC_WIDTH-1:0]  psum_r;
    logic                  ovf_bit;
    logic                  vld_r;

    if (j == 0) begin : g_first
      assign x = in_data;
      assign v = in_fire;
    end else begin : g_rest
      assign x = act_q[j-1];
      assign v = act_vld[j-1];
    end

    assign pin   = psum_in[j*ACC_WIDTH +: ACC_WIDTH];
    assign x_ext = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
    assign w_ext = {{DATA_WIDTH{active_w[j][DATA_WIDTH-1]}}, active_w[j]};
    // Full-width signed product fits exactly in PROD_W bits
    assign prod  = PROD_W'($signed(x_ext) * $signed(w_ext));

`ifdef SYS_ROW_SAT_EN
    logic [ACC_WIDTH:0] sum_wide;
    assign sum_wide = {pin[ACC_WIDTH-1], pin}
                    + {{(ACC_WIDTH+1-PROD_W){prod[PROD_W-1]}}, prod};
    assign ovf_bit  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign res      = !ovf_bit ? sum_wide[ACC_WIDTH-1:0] :
                      sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    logic ovf_r;
    always_ff @(posedge clk) begin
      if (reset) ovf_r <= 1'b0;
      else       ovf_r <= v & ovf_bit;
    end
    assign ovf[j] = ovf_r;
`else
    assign res     = pin + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    assign ovf_bit = 1'b0;
    assign ovf[j]  = ovf_bit;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        psum_r <= '0;
        vld_r  <= 1'b0;
      end else begin
        vld_r <= v;
        if (v) psum_r <= res;
      end
    end

    assign psum_out[j*ACC_WIDTH +: ACC_WIDTH] = psum_r;
    assign psum_valid[j]                      = vld_r;
  end

endmodule

// File: tb/tb_sys_array_row.sv
// Directed bench for sys_array_row (DATA_WIDTH=8, ACC_WIDTH=20, COLS=4).
module tb_sys_array_row;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wt_valid, wt_ready, wt_swap, swap_done;
  logic [DW-1:0] wt_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [C*AW-1:0] psum_in, psum_out;
  logic [C-1:0]  psum_valid, ovf;
  logic [DW-1:0] data_out;
  logic          data_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sys_array_row #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .COLS(C)) dut (
    .clk(clk), .reset(reset),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .wt_swap(wt_swap), .swap_done(swap_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .psum_in(psum_in), .psum_out(psum_out), .psum_valid(psum_valid),
    .data_out(data_out), .data_valid(data_valid), .ovf(ovf)
  );

  function automatic logic signed [AW-1:0] col(input int j);
    return $signed(psum_out[j*AW +: AW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [DW-1:0] a, b, c, d);
    logic [C-1:0][DW-1:0] w;
    w = {d, c, b, a};
    for (int k = 0; k < C; k++) begin
      wt_valid = 1'b1;
      wt_data  = w[k];
      tick();
    end
    wt_valid = 1'b0;
  endtask

  task automatic swap_wait(output bit ok);
    ok = 1'b0;
    wt_swap = 1'b1;
    tick();
    wt_swap = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (swap_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (psum_valid !== 4'b0) begin failures++; $display("FAIL reset_psum_valid got=%b exp=0000", psum_valid); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if (wt_ready !== 1'b1) begin failures++; $display("FAIL reset_wt_ready got=%b exp=1", wt_ready); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL reset_swap_done got=%b exp=0", swap_done); end
    in_valid = 1'b1; in_data = 8'd5; psum_in = '0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (psum_valid !== 4'b1000) begin failures++; $display("FAIL reset_zero_w_valid got=%b exp=1000", psum_valid); end
    checks++; if (psum_out !== '0) begin failures++; $display("FAIL reset_zero_w_psum got=%h exp=0", psum_out); end
  endtask

  task automatic test_basic();
    bit ok;
    load4(8'd1, 8'd2, 8'd3, 8'd4);
    swap_wait(ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_swap_done got=timeout exp=pulse"); end
    in_valid = 1'b1; in_data = 8'd5; psum_in = '0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < C; k++) begin
      if (k > 0) tick();
      checks++; if (psum_valid !== 4'(1 << k)) begin failures++; $display("FAIL basic_valid_%0d got=%b exp=%b", k, psum_valid, 4'(1 << k)); end
      checks++; if (col(k) !== 20'(5*(k+1))) begin failures++; $display("FAIL basic_psum_%0d got=%0d exp=%0d", k, col(k), 5*(k+1)); end
    end
    checks++; if (data_valid !== 1'b1 || data_out !== 8'd5) begin failures++; $display("FAIL basic_data_out got=%b/%0d exp=1/5", data_valid, data_out); end
  endtask

  task automatic test_back_to_back();
    int exp3 [3] = '{104, 92, 112};
    for (int j = 0; j < C; j++) psum_in[j*AW +: AW] = 20'd100;
    in_valid = 1'b1; in_data = 8'd1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) in_data = -8'sd2;
      if (c == 2) in_data = 8'sd3;
      if (c == 3) in_valid = 1'b0;
      if (c <= 3) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c == 1) begin
        checks++; if (col(0) !== 20'sd101) begin failures++; $display("FAIL b2b_col0 got=%0d exp=101", col(0)); end
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (psum_valid[3] !== 1'b1 || col(3) !== 20'(exp3[c-4])) begin
          failures++; $display("FAIL b2b_col3_%0d got=%b/%0d exp=1/%0d", c-4, psum_valid[3], col(3), exp3[c-4]);
        end
      end
    end
  endtask

  task automatic test_swap_mid_stream();
    int  done_cnt = 0, old_cnt = 0, new_cnt = 0;
    bit  seen_done = 1'b0, in_swap = 1'b0, saw_low = 1'b0;
    psum_in = '0;
    in_data = 8'd2;
    wt_data = 8'd7;
    for (int c = 0; c < 34; c++) begin
      in_valid = (c < 24);
      wt_valid = (c < 4);
      wt_swap  = (c == 5);
      tick();
      if (c == 5) in_swap = 1'b1;
      if (swap_done === 1'b1) begin done_cnt++; seen_done = 1'b1; in_swap = 1'b0; end
      if (in_swap) begin
        if (in_ready === 1'b0) saw_low = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL swap_in_ready_drain c=%0d got=%b exp=0", c, in_ready); end
      end
      if (psum_valid[3] === 1'b1) begin
        checks++;
        if (col(3) !== (seen_done ? 20'sd14 : 20'sd8)) begin
          failures++; $display("FAIL swap_col3 c=%0d got=%0d exp=%0d", c, col(3), seen_done ? 14 : 8);
        end
        if (seen_done) new_cnt++; else old_cnt++;
      end
    end
    wt_valid = 1'b0; wt_swap = 1'b0; in_valid = 1'b0;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL swap_done_count got=%0d exp=1", done_cnt); end
    checks++; if (!saw_low) begin failures++; $display("FAIL swap_in_ready_low got=never exp=low"); end
    checks++; if (old_cnt == 0 || new_cnt == 0) begin failures++; $display("FAIL swap_old_new got=%0d/%0d exp=nonzero", old_cnt, new_cnt); end
  endtask

  task automatic test_saturation();
    bit ok;
    logic signed [AW-1:0] exp_p;
    logic                 exp_o;
`ifdef SYS_ROW_SAT_EN
    exp_p = 20'sd524287; exp_o = 1'b1;
`else
    exp_p = -20'sd508160; exp_o = 1'b0;
`endif
    load4(8'd127, 8'd0, 8'd0, 8'd0);
    swap_wait(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sat_swap_done got=timeout exp=pulse"); end
    psum_in = '0;
    psum_in[AW-1:0] = 20'sd524287;
    in_valid = 1'b1; in_data = 8'd127;
    tick();
    in_valid = 1'b0;
    checks++; if (col(0) !== exp_p) begin failures++; $display("FAIL sat_psum0 got=%0d exp=%0d", col(0), exp_p); end
    checks++; if (ovf[0] !== exp_o || psum_valid[0] !== 1'b1) begin failures++; $display("FAIL sat_ovf0 got=%b/%b exp=%b/1", ovf[0], psum_valid[0], exp_o); end
    tick(); tick(); tick(); tick();
    checks++; if (ovf !== 4'b0) begin failures++; $display("FAIL sat_ovf_clear got=%b exp=0000", ovf); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    psum_in = '0;
    wt_valid = 1'b1; wt_data = 8'd5;
    tick(); tick();
    wt_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (wt_ready !== 1'b1 || psum_valid !== 4'b0) begin failures++; $display("FAIL midrst_state got=%b/%b exp=1/0000", wt_ready, psum_valid); end
    load4(8'd9, 8'd9, 8'd9, 8'd9);
    checks++; if (wt_ready !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b exp=0", wt_ready); end
    swap_wait(ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_swap_done got=timeout exp=pulse"); end
    in_valid = 1'b1; in_data = 8'd1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < C; k++) begin
      if (k > 0) tick();
      checks++; if (col(k) !== 20'sd9) begin failures++; $display("FAIL midrst_w_%0d got=%0d exp=9", k, col(k)); end
    end
  endtask

  initial begin
    reset = 1'b1; wt_valid = 1'b0; wt_data = '0; wt_swap = 1'b0;
    in_valid = 1'b0; in_data = '0; psum_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_swap_mid_stream();
    test_saturation();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
